pll_lock_supervisor: RTL and testbench

Reset-side companion for the system PLL wrapper: generates the PLL's `rst` pulse, watches the PLL's `locked` output, and releases a clean synchronous core reset only after lock has been stable for a programmable time. It retries PLL reset on lock timeout, re-sequences on lock loss, and flags permanent failure. It runs in the reference-clock domain, since it must operate while the PLL outputs are dead.

---
 rtl/pll_lock_supervisor.sv | 161 ++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock supervisor on the reference clock. It releases the core
// reset once lock has been stable, and re-sequences the PLL when lock is lost.
// Optional macro PLL_SUP_RETRY_EN enables the lock timeout, the retries and the FAIL state.
module pll_lock_supervisor #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 50000,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRIES   = 3
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       sys_reset,
   output logic       running,
   output logic       failed,
   output logic [3:0] retry_cnt,
   output logic [7:0] lost_cnt
);

   localparam int CNT_MAX0 = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int CNT_MAX  = (CNT_MAX0 > STABLE_CYCLES) ? CNT_MAX0 : STABLE_CYCLES;
   localparam int CW       = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

   typedef enum logic [2:0] {
      S_RESET_PLL = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RUN       = 3'd3,
      S_FAIL      = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    retry_q, retry_d;
   logic [7:0]    lost_q, lost_d;
   logic [1:0]    sync_q;
   logic          lk_s;
   logic          pll_rst_q, pll_rst_d;
   logic          sys_reset_q, sys_reset_d;
   logic          running_q, running_d;
   logic          failed_q, failed_d;

   assign lk_s = sync_q[1];

   // State, counters, synchronizer and registered output decodes
   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q     <= S_RESET_PLL;
         cnt_q       <= '0;
         retry_q     <= 4'd0;
         lost_q      <= 8'd0;
         sync_q      <= 2'b00;
         pll_rst_q   <= 1'b1;
         sys_reset_q <= 1'b1;
         running_q   <= 1'b0;
         failed_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         lost_q      <= lost_d;
         sync_q      <= {sync_q[0], pll_locked};
         pll_rst_q   <= pll_rst_d;
         sys_reset_q <= sys_reset_d;
         running_q   <= running_d;
         failed_q    <= failed_d;
      end
   end

   // Next state, shared counter, event counters and the decode of the next state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      retry_d = retry_q;
      lost_d  = lost_q;
      case (state_q)
         S_RESET_PLL: begin
            if (cnt_q == CW'(RST_CYCLES - 1)) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end else begin
               state_d = S_RESET_PLL;
            end
         end
         S_WAIT_LOCK: begin
            // Lock is tested first, so it wins over a coincident terminal count
            if (lk_s) begin
               state_d = S_STABLE;
               cnt_d   = '0;
`ifdef PLL_SUP_RETRY_EN
            end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
               cnt_d = '0;
               if (retry_q < 4'(MAX_RETRIES)) begin
                  retry_d = retry_q + 4'd1;
                  state_d = S_RESET_PLL;
               end else begin
                  state_d = S_FAIL;
               end
            end else begin
               state_d = S_WAIT_LOCK;
            end
`else
            end else begin
               cnt_d = '0;
            end
`endif
         end
         S_STABLE: begin
            if (!lk_s) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end else begin
               state_d = S_STABLE;
            end
         end
         S_RUN: begin
            cnt_d = '0;
            if (!lk_s) begin
               state_d = S_RESET_PLL;
               retry_d = 4'd0;
               lost_d  = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;
            end else begin
               state_d = S_RUN;
            end
         end
         S_FAIL: begin
            cnt_d = '0;
         end
         default: begin
            state_d = S_RESET_PLL;
            cnt_d   = '0;
         end
      endcase
      pll_rst_d   = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
      sys_reset_d = (state_d != S_RUN);
      running_d   = (state_d == S_RUN);
      failed_d    = (state_d == S_FAIL);
   end

`ifdef PLL_SUP_RETRY_EN
   assign retry_cnt = retry_q;
   assign failed    = failed_q;
`else
   logic [3:0] unused_retry_s;
   logic       unused_failed_s;
   assign unused_retry_s  = retry_q ^ 4'(MAX_RETRIES);
   assign unused_failed_s = failed_q;
   assign retry_cnt       = 4'd0;
   assign failed          = 1'b0;
`endif

   assign pll_rst   = pll_rst_q;
   assign sys_reset = sys_reset_q;
   assign running   = running_q;
   assign lost_cnt  = lost_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with RST_CYCLES=4, LOCK_TIMEOUT=20,
// STABLE_CYCLES=8 and MAX_RETRIES=2; the retry tests follow PLL_SUP_RETRY_EN.
module tb_pll_lock_supervisor;
   logic       refclk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_locked = 1'b0;
   logic       pll_rst, sys_reset, running, failed;
   logic [3:0] retry_cnt;
   logic [7:0] lost_cnt;
   int         vectors = 0;
   int         miscompares = 0;

   pll_lock_supervisor #(
      .RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8), .MAX_RETRIES(2)
   ) dut (
      .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .pll_rst(pll_rst),
      .sys_reset(sys_reset), .running(running), .failed(failed),
      .retry_cnt(retry_cnt), .lost_cnt(lost_cnt)
   );

   always #5 refclk = ~refclk;

   task automatic tick();
      @(posedge refclk);
      #1;
   endtask

   task automatic do_reset(input logic lock);
      pll_locked = lock;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset(1'b1);
      vectors++;
      if ({pll_rst, sys_reset, running, failed, retry_cnt, lost_cnt} !== {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0}) begin
         miscompares++;
         $display("FAIL reset_state: got pr=%b sr=%b run=%b f=%b rc=%0d lc=%0d, expected 1 1 0 0 0 0",
                  pll_rst, sys_reset, running, failed, retry_cnt, lost_cnt);
      end
   endtask

   task automatic test_bringup();
      do_reset(1'b1);
      for (int e = 1; e <= 15; e++) begin
         tick();
         vectors++;
         if (pll_rst !== (e < 4) || sys_reset !== (e < 13) || running !== (e >= 13)) begin
            miscompares++;
            $display("FAIL bringup edge %0d: got pr=%b sr=%b run=%b, expected %b %b %b",
                     e, pll_rst, sys_reset, running, e < 4, e < 13, e >= 13);
         end
      end
   endtask

   task automatic test_glitch();
      do_reset(1'b0);
      for (int e = 1; e <= 24; e++) begin
         tick();
         if (e == 4 || e == 12) pll_locked = 1'b1;
         if (e == 10) pll_locked = 1'b0;
         vectors++;
         if (sys_reset !== (e < 23) || running !== (e >= 23) || retry_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL glitch edge %0d: got sr=%b run=%b rc=%0d, expected %b %b 0",
                     e, sys_reset, running, retry_cnt, e < 23, e >= 23);
         end
      end
   endtask

   // Brings the design to RUN from reset with lock held high.
   task automatic reach_run();
      do_reset(1'b1);
      for (int e = 1; e <= 13; e++) tick();
   endtask

   task automatic test_lock_loss();
      int k;
      reach_run();
      pll_locked = 1'b0;
      k = 0;
      while (sys_reset !== 1'b1 && k < 8) begin
         tick();
         k++;
      end
      pll_locked = 1'b1;
      vectors++;
      if (k > 3 || sys_reset !== 1'b1 || lost_cnt !== 8'd1 || pll_rst !== 1'b1) begin
         miscompares++;
         $display("FAIL lock_loss: sr after %0d clocks, sr=%b lc=%0d pr=%b, expected <=3 1 1 1",
                  k, sys_reset, lost_cnt, pll_rst);
      end
      for (int j = 1; j <= 14; j++) begin
         tick();
         vectors++;
         if (pll_rst !== (j < 4) || running !== (j >= 13)) begin
            miscompares++;
            $display("FAIL relock clock %0d: got pr=%b run=%b, expected %b %b",
                     j, pll_rst, running, j < 4, j >= 13);
         end
      end
   endtask

   task automatic test_saturate();
      int k;
      reach_run();
      for (int i = 0; i < 258; i++) begin
         pll_locked = 1'b0;
         k = 0;
         while (sys_reset !== 1'b1 && k < 8) begin
            tick();
            k++;
         end
         pll_locked = 1'b1;
         while (running !== 1'b1 && k < 40) begin
            tick();
            k++;
         end
         vectors++;
         if (lost_cnt !== ((i >= 254) ? 8'd255 : 8'(i + 1)) || running !== 1'b1) begin
            miscompares++;
            $display("FAIL lost_sat iter %0d: got lc=%0d run=%b, expected %0d 1",
                     i, lost_cnt, running, (i >= 254) ? 255 : i + 1);
         end
      end
   endtask

`ifdef PLL_SUP_RETRY_EN
   task automatic test_timeout();
      logic       exp_pr;
      logic [3:0] exp_rc;
      do_reset(1'b0);
      for (int e = 1; e <= 80; e++) begin
         tick();
         exp_pr = (e < 4) || (e >= 24 && e < 28) || (e >= 48 && e < 52) || (e >= 72);
         exp_rc = (e < 24) ? 4'd0 : ((e < 48) ? 4'd1 : 4'd2);
         vectors++;
         if (pll_rst !== exp_pr || failed !== (e >= 72) || retry_cnt !== exp_rc || sys_reset !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout edge %0d: got pr=%b f=%b rc=%0d sr=%b, expected %b %b %0d 1",
                     e, pll_rst, failed, retry_cnt, sys_reset, exp_pr, e >= 72, exp_rc);
         end
      end
   endtask

   task automatic test_midrun_reset();
      int k;
      reach_run();
      pll_locked = 1'b0;
      k = 0;
      while (sys_reset !== 1'b1 && k < 8) begin
         tick();
         k++;
      end
      for (int j = 1; j <= 30; j++) tick();
      vectors++;
      if (retry_cnt !== 4'd1 || lost_cnt !== 8'd1 || pll_rst !== 1'b0) begin
         miscompares++;
         $display("FAIL pre_reset: got rc=%0d lc=%0d pr=%b, expected 1 1 0", retry_cnt, lost_cnt, pll_rst);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vectors++;
      if (retry_cnt !== 4'd0 || pll_rst !== 1'b1 || sys_reset !== 1'b1 || lost_cnt !== 8'd0 || failed !== 1'b0) begin
         miscompares++;
         $display("FAIL midrun_reset: got rc=%0d pr=%b sr=%b lc=%0d f=%b, expected 0 1 1 0 0",
                  retry_cnt, pll_rst, sys_reset, lost_cnt, failed);
      end
   endtask
`else
   task automatic test_no_retry();
      do_reset(1'b0);
      for (int e = 1; e <= 1000; e++) begin
         tick();
         vectors++;
         if (pll_rst !== (e < 4) || failed !== 1'b0 || retry_cnt !== 4'd0 || sys_reset !== 1'b1) begin
            miscompares++;
            $display("FAIL no_retry edge %0d: got pr=%b f=%b rc=%0d sr=%b, expected %b 0 0 1",
                     e, pll_rst, failed, retry_cnt, sys_reset, e < 4);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_bringup();
      test_glitch();
      test_lock_loss();
`ifdef PLL_SUP_RETRY_EN
      test_timeout();
      test_midrun_reset();
`else
      test_no_retry();
`endif
      test_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
